// File: rtl/cc_wb_master.sv
// cc_wb_master
// Turns OpenHPSDR protocol-1 command-and-control frames into Wishbone register
// writes on the radio's slave port (clk_ad9866 domain).
//
// Ports:
//   clk_ad9866   sole clock
//   extreset     synchronous active-low reset
//   cmd_tdata    {C0,C1,C2,C3,C4}, C0 in [39:32]
//   cmd_tvalid   frame valid
//   cmd_tready   command queue can accept (low while in reset)
//   ptt          MOX bit (C0[0]) of the most recently accepted frame
//   wbm_adr_o    write address (C0[6:1])
//   wbm_dat_o    write data {C1,C2,C3,C4}
//   wbm_we_o     write enable
//   wbm_stb_o    strobe
//   wbm_cyc_o    cycle
//   wbm_ack_i    slave acknowledge (only honoured while waiting for one)
//   timeout_err  sticky: an ack-class write ran out of ack cycles
module cc_wb_master #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 6,
    parameter int FIFO_DEPTH    = 4,
    parameter int ACK_TIMEOUT   = 15
) (
    input  logic                     clk_ad9866,
    input  logic                     extreset,
    input  logic [39:0]              cmd_tdata,
    input  logic                     cmd_tvalid,
    output logic                     cmd_tready,
    output logic                     ptt,
    output logic [WB_ADDR_WIDTH-1:0] wbm_adr_o,
    output logic [WB_DATA_WIDTH-1:0] wbm_dat_o,
    output logic                     wbm_we_o,
    output logic                     wbm_stb_o,
    output logic                     wbm_cyc_o,
    input  logic                     wbm_ack_i,
    output logic                     timeout_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef logic [PTR_W:0] ptr_t;
    typedef enum logic [1:0] {IDLE, POST, WAIT, GAP} state_t;

    state_t state, state_n;

    logic [WB_ADDR_WIDTH-1:0] fifo_adr [FIFO_DEPTH];
    logic [WB_DATA_WIDTH-1:0] fifo_dat [FIFO_DEPTH];
    ptr_t                     wr_ptr, rd_ptr;
    logic                     full, empty;
    logic                     accept, push, pop;
    logic [WB_ADDR_WIDTH-1:0] head_adr;
    logic [WB_DATA_WIDTH-1:0] head_dat;
    logic                     head_is_ack;
    logic [4:0]               wait_cnt;
    logic                     timeout_hit;

    // Extra pointer MSB distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign cmd_tready = ~full & extreset;
    assign accept     = cmd_tvalid & cmd_tready;
    // C0[7] marks a frame that only carries PTT; it never reaches the bus.
    assign push       = accept & ~cmd_tdata[39];

    assign head_adr = fifo_adr[rd_ptr[PTR_W-1:0]];
    assign head_dat = fifo_dat[rd_ptr[PTR_W-1:0]];

    // Frequency/NCO registers answer with a multi-cycle ack; the rest are posted.
    assign head_is_ack =
        ((head_adr >= WB_ADDR_WIDTH'(8'h01)) && (head_adr <= WB_ADDR_WIDTH'(8'h08))) ||
        ((head_adr >= WB_ADDR_WIDTH'(8'h12)) && (head_adr <= WB_ADDR_WIDTH'(8'h16)));

    always_ff @(posedge clk_ad9866) begin
        if (push) begin
            fifo_adr[wr_ptr[PTR_W-1:0]] <= WB_ADDR_WIDTH'(cmd_tdata[38:33]);
            fifo_dat[wr_ptr[PTR_W-1:0]] <= WB_DATA_WIDTH'(cmd_tdata[31:0]);
        end
    end

    always_comb begin
        state_n     = state;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            // GAP already provides the strobe-low cycle, so it may launch the
            // next queued write directly; this keeps posted writes at one per
            // 2 cycles and acked writes at one per 5.
            IDLE, GAP: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = head_is_ack ? WAIT : POST;
                end else begin
                    state_n = IDLE;
                end
            end
            POST: state_n = GAP;
            WAIT: begin
                if (wbm_ack_i) begin
                    state_n = GAP;
                end else if (wait_cnt == 5'(ACK_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_n     = GAP;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_ad9866) begin
        if (!extreset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ptt         <= 1'b0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                ptt <= cmd_tdata[32];
            end
            if (push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + ptr_t'(1);
                wbm_adr_o <= head_adr;
                wbm_dat_o <= head_dat;
            end
            // Counts stb cycles spent in WAIT; zero on every entry.
            wait_cnt <= (state == WAIT) ? wait_cnt + 5'd1 : '0;
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign wbm_stb_o = (state == POST) || (state == WAIT);
    assign wbm_cyc_o = wbm_stb_o;
    assign wbm_we_o  = wbm_stb_o;

endmodule
